// File: rtl/piezo_pkg.sv
// Shared types, alert timing table and priority arbiter for the piezo alert scheduler.
package piezo_pkg;

  typedef enum logic [1:0] {
    NONE  = 2'd0,
    STEER = 2'd1,
    BATT  = 2'd2,
    OVR   = 2'd3
  } alert_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    TONE = 2'd1,
    GAP  = 2'd2
  } state_e;

  typedef struct packed {
    logic [10:0] tone_len;  // ticks
    logic [10:0] gap_len;   // ticks
    logic [15:0] half_per;  // clk cycles per half wave
  } alert_cfg_t;

  localparam int unsigned FAST_DIV = 16;

  // Indexed by alert_e; NONE entry is never played.
  localparam alert_cfg_t ALERT_T [4] = '{
    '{tone_len: 11'd0,   gap_len: 11'd0,    half_per: 16'd1},
    '{tone_len: 11'd200, gap_len: 11'd1800, half_per: 16'd16384},
    '{tone_len: 11'd300, gap_len: 11'd700,  half_per: 16'd32768},
    '{tone_len: 11'd100, gap_len: 11'd100,  half_per: 16'd4096}
  };

  function automatic alert_e pick_winner(input logic ovr, input logic batt, input logic steer);
    if (ovr)   return OVR;
    if (batt)  return BATT;
    if (steer) return STEER;
    return NONE;
  endfunction

endpackage

// File: rtl/piezo_tone_gen.sv
// Square-wave generator: wave toggles every half_per clk while enabled; clr restarts low.
module piezo_tone_gen (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic [15:0] half_per,
  output logic        wave
);

  logic [15:0] cnt;

  // Half-period counter; wave flips on each wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      wave <= 1'b0;
    end else if (en) begin
      if (cnt == half_per - 16'd1) begin
        cnt  <= '0;
        wave <= ~wave;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

endmodule

// File: rtl/piezo_alert_sched.sv
// Piezo alert scheduler: fixed-priority arbitration of three alert requests,
// tone/gap sequencing on a 1 ms tick, differential piezo drive.
module piezo_alert_sched
  import piezo_pkg::*;
#(
  parameter bit          fast_sim = 1'b0,
  parameter int unsigned TICK_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ovr_spd,
  input  logic       batt_low,
  input  logic       en_steer,
  input  logic       mute,
  output logic       piezo,
  output logic       piezo_n,
  output logic [1:0] active
);

  localparam int unsigned DIV = fast_sim ? FAST_DIV : TICK_DIV;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);

  state_e      state;
  alert_e      cur;
  alert_e      winner;
  alert_cfg_t  cfg;
  logic [PW-1:0] pre_cnt;
  logic [10:0] ph_cnt;
  logic [10:0] phase_len;
  logic        tick;
  logic        phase_end;
  logic        cur_req;
  logic        preempt;
  logic        tone_clr;
  logic        tone_en;
  logic        wave;

  // Arbitration, table lookup and phase/preempt decode.
  always_comb begin
    winner    = pick_winner(ovr_spd, batt_low, en_steer);
    cfg       = ALERT_T[cur];
    tick      = (pre_cnt == PRE_MAX);
    phase_len = (state == TONE) ? cfg.tone_len : cfg.gap_len;
    phase_end = tick && (ph_cnt == phase_len - 11'd1);
    unique case (cur)
      STEER:   cur_req = en_steer;
      BATT:    cur_req = batt_low;
      OVR:     cur_req = ovr_spd;
      default: cur_req = 1'b0;
    endcase
    // Level test is equivalent to a rising-edge test here: a held ovr_spd
    // always wins arbitration, so cur!=OVR with ovr_spd high means it just rose.
    preempt  = ovr_spd && (cur != OVR) && (state != IDLE);
    tone_en  = (state == TONE);
    tone_clr = (state != TONE) || preempt || mute;
  end

  piezo_tone_gen u_tone (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (tone_clr),
    .en       (tone_en),
    .half_per (cfg.half_per),
    .wave     (wave)
  );

  // Alert FSM with prescaler, phase counter and registered pin drive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cur     <= NONE;
      pre_cnt <= '0;
      ph_cnt  <= '0;
      piezo   <= 1'b0;
      piezo_n <= 1'b0;
      active  <= 2'd0;
    end else begin
      piezo   <= (state == TONE) && wave;
      piezo_n <= (state == TONE) && !wave;
      active  <= cur;

      if (mute) begin
        state   <= IDLE;
        cur     <= NONE;
        pre_cnt <= '0;
        ph_cnt  <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            pre_cnt <= '0;
            ph_cnt  <= '0;
            if (winner != NONE) begin
              state <= TONE;
              cur   <= winner;
            end
          end
          TONE, GAP: begin
            if (preempt) begin
              state   <= TONE;
              cur     <= OVR;
              pre_cnt <= '0;
              ph_cnt  <= '0;
            end else if (!cur_req) begin
              state   <= IDLE;
              cur     <= NONE;
              pre_cnt <= '0;
              ph_cnt  <= '0;
            end else begin
              pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
              if (phase_end) begin
                ph_cnt <= '0;
                if (state == TONE) begin
                  state <= GAP;
                end else if (winner != NONE) begin
                  state <= TONE;
                  cur   <= winner;
                end else begin
                  state <= IDLE;
                  cur   <= NONE;
                end
              end else if (tick) begin
                ph_cnt <= ph_cnt + 11'd1;
              end
            end
          end
          default: begin
            state   <= IDLE;
            cur     <= NONE;
            pre_cnt <= '0;
            ph_cnt  <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_piezo_alert_sched.sv
// Scoreboard bench for piezo_alert_sched: two instances (fast_sim tick and a
// short real-tick divider) checked against a time-based reference model.
module tb_piezo_alert_sched;

  localparam int unsigned DIV_A = 16;
  localparam int unsigned DIV_B = 64;

  localparam int TONE_T [4] = '{0, 200, 300, 100};
  localparam int GAP_T  [4] = '{0, 1800, 700, 100};
  localparam int HALF_T [4] = '{1, 16384, 32768, 4096};

  logic clk, rst_n, ovr_spd, batt_low, en_steer, mute;
  logic pz_a, pn_a, pz_b, pn_b;
  logic [1:0] act_a, act_b;

  int n_checks;
  int n_fail;
  int cyc;

  // mode: 0 silent, 1 sounding, 2 pause; e = clk edges since the phase began
  typedef struct {
    int          mode;
    int          alert;
    int unsigned e;
    logic        pz;
    logic        pn;
    logic [1:0]  act;
  } mdl_t;

  typedef struct packed {
    logic       pz_a;
    logic       pn_a;
    logic [1:0] act_a;
    logic       pz_b;
    logic       pn_b;
    logic [1:0] act_b;
  } exp_t;

  mdl_t ma, mb;
  exp_t expq[$];

  piezo_alert_sched #(.fast_sim(1'b1), .TICK_DIV(50000)) dut_a (
    .clk(clk), .rst_n(rst_n), .ovr_spd(ovr_spd), .batt_low(batt_low),
    .en_steer(en_steer), .mute(mute), .piezo(pz_a), .piezo_n(pn_a), .active(act_a)
  );

  piezo_alert_sched #(.fast_sim(1'b0), .TICK_DIV(DIV_B)) dut_b (
    .clk(clk), .rst_n(rst_n), .ovr_spd(ovr_spd), .batt_low(batt_low),
    .en_steer(en_steer), .mute(mute), .piezo(pz_b), .piezo_n(pn_b), .active(act_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.mode = 0; m.alert = 0; m.e = 0;
    m.pz = 1'b0; m.pn = 1'b0; m.act = 2'd0;
    return m;
  endfunction

  // One clock of the reference behaviour: outputs reflect the pre-edge phase.
  function automatic mdl_t step(mdl_t m, int unsigned div, logic ov, logic bl, logic st, logic mu);
    mdl_t n;
    int   w;
    logic req;
    logic wv;
    n   = m;
    wv  = ((m.e / HALF_T[m.alert]) % 2) == 1;
    n.pz  = (m.mode == 1) && wv;
    n.pn  = (m.mode == 1) && !wv;
    n.act = (m.mode == 0) ? 2'd0 : 2'(m.alert);
    w   = ov ? 3 : bl ? 2 : st ? 1 : 0;
    req = (m.alert == 3) ? ov : (m.alert == 2) ? bl : (m.alert == 1) ? st : 1'b0;
    if (mu) begin
      n.mode = 0; n.alert = 0; n.e = 0;
    end else if (m.mode == 0) begin
      if (w != 0) begin
        n.mode = 1; n.alert = w; n.e = 0;
      end
    end else if (ov && m.alert != 3) begin
      n.mode = 1; n.alert = 3; n.e = 0;
    end else if (!req) begin
      n.mode = 0; n.alert = 0; n.e = 0;
    end else begin
      n.e = m.e + 1;
      if (m.mode == 1 && n.e == div * TONE_T[m.alert]) begin
        n.mode = 2; n.e = 0;
      end else if (m.mode == 2 && n.e == div * GAP_T[m.alert]) begin
        n.e = 0;
        if (w != 0) begin
          n.mode = 1; n.alert = w;
        end else begin
          n.mode = 0; n.alert = 0;
        end
      end
    end
    return n;
  endfunction

  task automatic run(input int n);
    exp_t x;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      ma = step(ma, DIV_A, ovr_spd, batt_low, en_steer, mute);
      mb = step(mb, DIV_B, ovr_spd, batt_low, en_steer, mute);
      x.pz_a = ma.pz; x.pn_a = ma.pn; x.act_a = ma.act;
      x.pz_b = mb.pz; x.pn_b = mb.pn; x.act_b = mb.act;
      expq.push_back(x);
      cyc++;
      @(negedge clk);
    end
  endtask

  task automatic set_req(input logic ov, input logic bl, input logic st);
    ovr_spd = ov; batt_low = bl; en_steer = st;
  endtask

  // Asynchronous reset between edges; outputs must clear without a clock.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({pz_a, pn_a, act_a, pz_b, pn_b, act_b} !== 8'h00) begin
      n_fail++;
      $display("FAIL async_reset cyc=%0d got a:%b%b%0d b:%b%b%0d expected all 0",
               cyc, pz_a, pn_a, act_a, pz_b, pn_b, act_b);
    end
    ma = mdl_reset();
    mb = mdl_reset();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every presented output cycle is matched against the scoreboard.
  always @(negedge clk) begin
    exp_t x;
    if (expq.size() > 0) begin
      x = expq.pop_front();
      n_checks++;
      if ({pz_a, pn_a, act_a} !== {x.pz_a, x.pn_a, x.act_a}) begin
        n_fail++;
        $display("FAIL fast_sim cyc=%0d got pz=%b pn=%b act=%0d expected pz=%b pn=%b act=%0d",
                 cyc, pz_a, pn_a, act_a, x.pz_a, x.pn_a, x.act_a);
      end
      n_checks++;
      if ({pz_b, pn_b, act_b} !== {x.pz_b, x.pn_b, x.act_b}) begin
        n_fail++;
        $display("FAIL div64 cyc=%0d got pz=%b pn=%b act=%0d expected pz=%b pn=%b act=%0d",
                 cyc, pz_b, pn_b, act_b, x.pz_b, x.pn_b, x.act_b);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got no finish expected finish within time limit", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0; n_fail = 0; cyc = 0;
    rst_n = 1'b1;
    mute  = 1'b0;
    set_req(1'b0, 1'b0, 1'b0);
    ma = mdl_reset();
    mb = mdl_reset();
    @(negedge clk);
    do_reset();
    run(4);

    // steer chirp: full tone/gap period plus the start of the repeat
    set_req(1'b0, 1'b0, 1'b1);
    run(32500);
    set_req(1'b0, 1'b0, 1'b0);
    run(20);

    // over-speed for 5000 clk
    set_req(1'b1, 1'b0, 1'b0);
    run(5000);
    set_req(1'b0, 1'b0, 1'b0);
    run(20);

    // steer tone preempted by over-speed 1000 clk in
    set_req(1'b0, 1'b0, 1'b1);
    run(1002);
    set_req(1'b1, 1'b0, 1'b1);
    run(3000);
    set_req(1'b0, 1'b0, 1'b0);
    run(20);

    // batt_low during steer tone waits for the steer gap, then is dropped mid-tone
    set_req(1'b0, 1'b0, 1'b1);
    run(1500);
    set_req(1'b0, 1'b1, 1'b1);
    run(33000);
    set_req(1'b0, 1'b0, 1'b1);
    run(200);
    set_req(1'b0, 1'b0, 1'b0);
    run(20);

    // async reset mid over-speed pattern
    set_req(1'b1, 1'b0, 1'b0);
    run(2400);
    do_reset();
    run(500);

    // one-clk mute pulse during over-speed tone
    run(300);
    mute = 1'b1;
    run(1);
    mute = 1'b0;
    run(2500);
    set_req(1'b0, 1'b0, 1'b0);
    run(20);

    // random request/mute activity
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 999) < 4) ovr_spd  = ~ovr_spd;
      if ($urandom_range(0, 999) < 4) batt_low = ~batt_low;
      if ($urandom_range(0, 999) < 6) en_steer = ~en_steer;
      mute = ($urandom_range(0, 999) < 3);
      run(1);
    end
    mute = 1'b0;
    set_req(1'b0, 1'b0, 1'b0);
    run(10);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
